// File: rtl/instruction_memory.sv
// Execute stage of the 8-bit CPU. It latches an operand pair and an opcode, then
// computes the ALU result combinationally and keeps a registered copy for write-back.
module instruction_memory #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic [OPW-1:0]   alu_sel,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CMP = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic               div_zero;
  logic               a_lt_b;
  logic               a_eq_b;
  logic               a_gt_b;

  // Operand and select capture; reset is active-low and asynchronous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r     <= '0;
      b_r     <= '0;
      alu_sel <= '0;
    end else begin
      a_r     <= a;
      b_r     <= b;
      alu_sel <= opcode;
    end
  end

  // Arithmetic building blocks, all sized so no result bits are lost.
  always_comb begin
    sum      = {1'b0, a_r} + {1'b0, b_r};
    diff     = {1'b0, a_r} - {1'b0, b_r};
    prod     = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    div_zero = (b_r == '0);
    quot     = div_zero ? '1 : (a_r / b_r);
    a_lt_b   = (a_r < b_r);
    a_eq_b   = (a_r == b_r);
    a_gt_b   = (a_r > b_r);
  end

  always_comb begin
    alu_out   = '0;
    carry_out = 1'b0;
    case (alu_op_e'(alu_sel))
      OP_ADD: begin
        alu_out   = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_SUB: begin
        alu_out   = diff[WIDTH-1:0];
        carry_out = a_lt_b;
      end
      OP_AND: alu_out = a_r & b_r;
      OP_OR:  alu_out = a_r | b_r;
      OP_XOR: alu_out = a_r ^ b_r;
      OP_MUL: begin
        alu_out   = prod[WIDTH-1:0];
        carry_out = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        alu_out   = quot;
        carry_out = div_zero;
      end
      OP_CMP: alu_out = {{(WIDTH-3){1'b0}}, a_lt_b, a_eq_b, a_gt_b};
      default: begin
        alu_out   = '0;
        carry_out = 1'b0;
      end
    endcase
  end

  // Write-back copy lags the combinational result by one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else begin
      data_out <= alu_out;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: directed vectors push expected results,
// a monitor pops and compares alu outputs one edge later and data_out two edges later.
module tb_instruction_memory;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] res;
    logic       cry;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       cry;
  } vec_t;

  exp_t       alu_q[$];
  logic [7:0] data_q[$];
  logic       issued = 1'b0;
  logic       alu_pend_prev = 1'b0;

  instruction_memory #(.WIDTH(8), .OPW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operation at the falling edge and record what it should produce.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    a      = v.a;
    b      = v.b;
    opcode = v.op;
    issued = 1'b1;
    e.sel  = v.op;
    e.res  = v.res;
    e.cry  = v.cry;
    alu_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      issued = 1'b0;
    end
  endtask

  // Monitor: an op issued before an edge shows on alu_out after it, on data_out one edge later.
  always @(posedge clk) begin
    logic v_alu;
    logic v_data;
    exp_t e;
    logic [7:0] d;
    v_alu         = issued;
    v_data        = alu_pend_prev;
    alu_pend_prev = v_alu;
    #1;
    if (v_data) begin
      if (data_q.size() == 0) begin
        check_output("data_q_underflow", 1, 0);
      end else begin
        d = data_q.pop_front();
        check_output("data_out", data_out, d);
      end
    end
    if (v_alu) begin
      if (alu_q.size() == 0) begin
        check_output("alu_q_underflow", 1, 0);
      end else begin
        e = alu_q.pop_front();
        check_output("alu_sel", alu_sel, e.sel);
        check_output("alu_out", alu_out, e.res);
        check_output("carry_out", carry_out, e.cry);
        data_q.push_back(e.res);
      end
    end
  end

  vec_t vecs[$] = '{
    '{8'd5,   8'd3,   3'b000, 8'd8,   1'b0},
    '{8'd5,   8'd3,   3'b001, 8'd2,   1'b0},
    '{8'd5,   8'd3,   3'b010, 8'd1,   1'b0},
    '{8'd5,   8'd3,   3'b011, 8'd7,   1'b0},
    '{8'd5,   8'd3,   3'b100, 8'd6,   1'b0},
    '{8'd5,   8'd3,   3'b101, 8'd15,  1'b0},
    '{8'd5,   8'd3,   3'b110, 8'd1,   1'b0},
    '{8'd5,   8'd3,   3'b111, 8'd1,   1'b0},
    '{8'd200, 8'd100, 3'b000, 8'd44,  1'b1},
    '{8'd3,   8'd5,   3'b001, 8'd254, 1'b1},
    '{8'd16,  8'd32,  3'b101, 8'd0,   1'b1},
    '{8'd15,  8'd17,  3'b101, 8'd255, 1'b0},
    '{8'd200, 8'd7,   3'b110, 8'd28,  1'b0},
    '{8'd9,   8'd0,   3'b110, 8'd255, 1'b1},
    '{8'd3,   8'd5,   3'b111, 8'd4,   1'b0},
    '{8'd7,   8'd7,   3'b111, 8'd2,   1'b0}
  };

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t late;
    reset  = 1'b0;
    a      = 8'd5;
    b      = 8'd3;
    opcode = 3'b101;

    // Reset held while clocking: nothing may be captured.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_alu_sel", alu_sel, 0);
    check_output("rst_alu_out", alu_out, 0);
    check_output("rst_carry", carry_out, 0);
    check_output("rst_data_out", data_out, 0);

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Change inputs between edges: alu_out must hold the CMP(7,7) result until the edge.
    late = '{8'd1, 8'd200, 3'b000, 8'd201, 1'b0};
    apply_stimulus(late);
    #2;
    check_output("hold_alu_out", alu_out, 2);
    idle_cycles(4);

    // Capture an op without the scoreboard, then reset mid-cycle before write-back.
    a      = 8'd200;
    b      = 8'd100;
    opcode = 3'b000;
    @(posedge clk);
    #1;
    check_output("pre_rst_alu_out", alu_out, 44);
    check_output("pre_rst_carry", carry_out, 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_alu_sel", alu_sel, 0);
    check_output("async_alu_out", alu_out, 0);
    check_output("async_carry", carry_out, 0);
    check_output("async_data_out", data_out, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("held_data_out", data_out, 0);

    @(negedge clk);
    reset = 1'b1;
    apply_stimulus('{8'd16, 8'd32, 3'b101, 8'd0, 1'b1});
    apply_stimulus('{8'd3, 8'd5, 3'b001, 8'd254, 1'b1});
    idle_cycles(4);

    check_output("queues_drained", alu_q.size() + data_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
